// File: rtl/encoder8_sync_if.sv
// Request/handshake bundle for encoder8_sync: eight request lines in, encoded index out.
interface encoder8_sync_if;
  logic       din_0;
  logic       din_1;
  logic       din_2;
  logic       din_3;
  logic       din_4;
  logic       din_5;
  logic       din_6;
  logic       din_7;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic [3:0] pend_cnt;

  // Requester/consumer side
  modport master (
    output din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7, sel_ready,
    input  sel, sel_valid, pend_cnt
  );

  // Encoder side
  modport slave (
    input  din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7, sel_ready,
    output sel, sel_valid, pend_cnt
  );
endinterface

// File: rtl/encoder8_sync.sv
// Registered 8-to-3 request encoder with latched pending set and valid/ready output.
// Define ENCODER8_ROUND_ROBIN_EN for round-robin selection; default is lowest-index priority.
module encoder8_sync (
  input logic             clk,
  input logic             rst_n,
  encoder8_sync_if.slave  bus
);
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic [N-1:0]  din;
  logic [N-1:0]  clr;
  logic [N-1:0]  pending_q, pending_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] start_d;
  logic          hs;

  // First set bit of req, searching upward from start with wrap.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      idx = start + IW'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] req);
    popcount = '0;
    for (int i = 0; i < int'(N); i++) begin
      popcount = popcount + CW'(req[i]);
    end
  endfunction

  assign din = {bus.din_7, bus.din_6, bus.din_5, bus.din_4,
                bus.din_3, bus.din_2, bus.din_1, bus.din_0};
  assign hs  = valid_q & bus.sel_ready;

`ifdef ENCODER8_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = sel_q + IW'(1);
    end
  end

  assign start_d = ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_d = '0;
`endif

  // Next pending set; a new request on the accepted index keeps it pending.
  always_comb begin
    clr       = '0;
    if (hs) begin
      clr = N'(1) << sel_q;
    end
    pending_d = (pending_q & ~clr) | din;
    valid_d   = |pending_d;
    sel_d     = pick(pending_d, start_d);
    cnt_d     = popcount(pending_d);
  end

  // Outputs are registered copies of what the next pending state decodes to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.pend_cnt  = cnt_q;
endmodule
